// File: rtl/test_monitor.sv
// Run-control monitor: snoops core write/retire activity, counts RUN cycles, ends the run on a
// tohost store (pass/fail) or cycle-budget expiry. Outputs are registered; there is no backpressure (pure observer).
module test_monitor #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   TOHOST_ADDR = 'h100,
  parameter int                MAX_CYCLES  = 1000,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              dmem_we,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic              rf_we,
  input  logic [4:0]        rf_rd,
  input  logic              retire,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  rf_write_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic [XLEN-2:0]   fail_code_q, fail_code_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;
  logic [CNT_W-1:0]  rf_write_count_q, rf_write_count_d;
  logic              hit;

  assign hit = dmem_we && (dmem_addr == TOHOST_ADDR);

  always_comb begin
    state_d          = state_q;
    fail_code_d      = fail_code_q;
    cycle_count_d    = cycle_count_q;
    retire_count_d   = retire_count_q;
    rf_write_count_d = rf_write_count_q;
    // clear leaves results intact so they can still be read back from IDLE
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d          = S_RUN;
            fail_code_d      = '0;
            cycle_count_d    = '0;
            retire_count_d   = '0;
            rf_write_count_d = '0;
          end
        end
        S_RUN: begin
          cycle_count_d = cycle_count_q + 1'b1;
          if (retire && (retire_count_q != '1)) retire_count_d = retire_count_q + 1'b1;
          if (rf_we && (rf_rd != 5'd0) && (rf_write_count_q != '1))
            rf_write_count_d = rf_write_count_q + 1'b1;
          // even-valued tohost stores are reserved and fall through to the budget check
          if (hit && (dmem_wdata == XLEN'(1))) begin
            state_d = S_PASS;
          end else if (hit && dmem_wdata[0]) begin
            state_d     = S_FAIL;
            fail_code_d = dmem_wdata[XLEN-1:1];
          end else if (cycle_count_q == LAST_CYCLE) begin
            state_d = S_TIMEOUT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      fail_code_q      <= '0;
      cycle_count_q    <= '0;
      retire_count_q   <= '0;
      rf_write_count_q <= '0;
    end else begin
      state_q          <= state_d;
      fail_code_q      <= fail_code_d;
      cycle_count_q    <= cycle_count_d;
      retire_count_q   <= retire_count_d;
      rf_write_count_q <= rf_write_count_d;
    end
  end

  assign running        = (state_q == S_RUN);
  assign done           = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign pass           = (state_q == S_PASS);
  assign timeout        = (state_q == S_TIMEOUT);
  assign fail_code      = fail_code_q;
  assign cycle_count    = cycle_count_q;
  assign retire_count   = retire_count_q;
  assign rf_write_count = rf_write_count_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: directed scenarios plus randomized runs scored against a run-level model.
module tb_test_monitor;

  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, clear = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_rd = '0;
  logic        retire = 1'b0;
  logic        running, done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, retire_count, rf_write_count;

  test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h100), .MAX_CYCLES(MAXC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .retire(retire),
    .running(running), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_count(cycle_count),
    .retire_count(retire_count), .rf_write_count(rf_write_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: run outcome plus plain integer tallies
  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TIMEOUT} mode_t;
  mode_t  m_mode = M_IDLE;
  longint m_cyc = 0, m_ret = 0, m_rfw = 0, m_fc = 0;
  localparam longint SAT = 64'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cyc = 0; m_ret = 0; m_rfw = 0; m_fc = 0;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else if (clear) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_RUN; m_cyc = 0; m_ret = 0; m_rfw = 0; m_fc = 0;
      end
    end else if (m_mode == M_RUN) begin
      m_cyc = m_cyc + 1;
      if (retire && m_ret < SAT) m_ret = m_ret + 1;
      if (rf_we && rf_rd != 0 && m_rfw < SAT) m_rfw = m_rfw + 1;
      if (dmem_we && dmem_addr == 32'h100 && dmem_wdata == 1) m_mode = M_PASS;
      else if (dmem_we && dmem_addr == 32'h100 && dmem_wdata % 2 == 1) begin
        m_mode = M_FAIL; m_fc = dmem_wdata / 2;
      end else if (m_cyc == MAXC) m_mode = M_TIMEOUT;
    end
  endtask

  task automatic check_all();
    chk("running", 64'(running), 64'(m_mode == M_RUN));
    chk("done", 64'(done), 64'(m_mode == M_PASS || m_mode == M_FAIL || m_mode == M_TIMEOUT));
    chk("pass", 64'(pass), 64'(m_mode == M_PASS));
    chk("timeout", 64'(timeout), 64'(m_mode == M_TIMEOUT));
    chk("fail_code", 64'(fail_code), m_fc);
    chk("cycle_count", 64'(cycle_count), m_cyc);
    chk("retire_count", 64'(retire_count), m_ret);
    chk("rf_write_count", 64'(rf_write_count), m_rfw);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0;
    rf_we = 0; rf_rd = 0; retire = 0;
  endtask

  // Random snoop traffic that never touches tohost
  task automatic rand_snoop();
    dmem_we    = 1'($urandom);
    dmem_addr  = ($urandom_range(0, 1) == 0) ? 32'h104 : ($urandom & 32'hFFFF_FE00);
    dmem_wdata = $urandom;
    rf_we      = 1'($urandom);
    rf_rd      = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    retire     = 1'($urandom);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    dmem_we = 1; dmem_addr = addr; dmem_wdata = data;
  endtask

  task automatic start_run();
    idle_inputs(); start = 1; tick(); start = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear = 1; tick(); clear = 0;
  endtask

  initial begin
    // Reset held with start and snoop activity
    idle_inputs(); rst = 0; start = 1;
    for (int i = 0; i < 4; i++) begin rand_snoop(); start = 1; tick(); end
    chk("reset_running", 64'(running), 64'd0);
    idle_inputs(); start = 1; rst = 1;
    tick();
    chk("start_running", 64'(running), 64'd1);
    chk("start_cycle0", 64'(cycle_count), 64'd0);
    start = 0;

    // Pass: 10 cycles of activity, tohost=1 in cycle 10
    for (int i = 0; i < 10; i++) begin retire = 1; rf_we = 1; rf_rd = 5; tick(); end
    store(32'h100, 32'd1); tick(); idle_inputs();
    chk("pass_flag", 64'(pass), 64'd1);
    chk("pass_cyc", 64'(cycle_count), 64'd11);
    chk("pass_ret", 64'(retire_count), 64'd11);
    chk("pass_rfw", 64'(rf_write_count), 64'd11);
    for (int i = 0; i < 3; i++) begin rand_snoop(); start = 1; store(32'h100, 32'd7); tick(); end

    // clear+start together in a terminal state goes to IDLE only
    idle_inputs(); clear = 1; start = 1; tick();
    chk("clear_idle", 64'(running), 64'd0);
    chk("clear_keep_cyc", 64'(cycle_count), 64'd11);
    clear = 0; tick();
    chk("restart_running", 64'(running), 64'd1);
    chk("restart_cyc", 64'(cycle_count), 64'd0);
    start = 0;

    // Fail: even store ignored, then 7 -> code 3
    store(32'h100, 32'd4); tick();
    chk("even_ignored", 64'(running), 64'd1);
    store(32'h100, 32'd7); tick(); idle_inputs();
    chk("fail_pass", 64'(pass), 64'd0);
    chk("fail_done", 64'(done), 64'd1);
    chk("fail_code3", 64'(fail_code), 64'd3);
    do_clear();

    // Filtering, off-address store, then timeout
    start_run();
    for (int i = 0; i < 5; i++) begin rf_we = 1; rf_rd = 0; tick(); end
    chk("rd0_filtered", 64'(rf_write_count), 64'd0);
    idle_inputs(); store(32'h104, 32'd1); tick(); idle_inputs();
    chk("addr104_run", 64'(running), 64'd1);
    for (int i = 0; i < 40 && m_mode == M_RUN; i++) tick();
    chk("timeout_flag", 64'(timeout), 64'd1);
    chk("timeout_cyc", 64'(cycle_count), 64'(MAXC));
    do_clear();

    // Tohost in the last budget cycle beats timeout
    start_run();
    while (m_mode == M_RUN && m_cyc < MAXC - 1) tick();
    store(32'h100, 32'd1); tick(); idle_inputs();
    chk("late_pass", 64'(pass), 64'd1);
    chk("late_no_timeout", 64'(timeout), 64'd0);
    chk("late_cyc", 64'(cycle_count), 64'(MAXC));
    do_clear();

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 2; i++) begin rand_snoop(); tick(); end
      start_run();
      for (int i = 0; i < MAXC + 5 && m_mode == M_RUN; i++) begin
        rand_snoop();
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 2))
            0: store(32'h100, 32'd1);
            1: store(32'h100, $urandom | 32'd1);
            default: store(32'h100, $urandom & ~32'd1);
          endcase
        end
        tick();
      end
      for (int i = 0; i < 3; i++) begin rand_snoop(); start = 1'($urandom); tick(); end
      do_clear();
    end

    // Asynchronous reset mid-run
    start_run();
    for (int i = 0; i < 4; i++) begin rand_snoop(); tick(); end
    #2 rst = 0;
    #1 model_reset(); check_all();
    chk("midrun_reset_cyc", 64'(cycle_count), 64'd0);
    @(negedge clk); idle_inputs(); rst = 1; tick();
    chk("post_reset_idle", 64'(running), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
